// File: rtl/life_row_sequencer.sv
// life_row_sequencer
// Runs one Game-of-Life generation through a row of column lanes. Rows of
// the current bank are streamed into the lanes. Each next-generation row is
// written to the opposite bank. Banks are swapped when the generation ends.
// Dead rows above and below the frame come from the lane clear and from a
// zero pad row.
module life_row_sequencer #(
   parameter int WIDTH  = 32,
   parameter int HEIGHT = 32,
   parameter int ROW_W  = 5
) (
   input  logic               clk,
   input  logic               rstn,
   input  logic               start,
   input  logic               halt,
   output logic               busy,
   output logic               done,
   output logic               bank,
   output logic [15:0]        gen_cnt,
   output logic               mem_rd_en,
   output logic [ROW_W:0]     mem_rd_addr,
   input  logic [WIDTH-1:0]   mem_rd_data,
   output logic               mem_wr_en,
   output logic [ROW_W:0]     mem_wr_addr,
   output logic [WIDTH-1:0]   mem_wr_data,
   output logic               lane_clr_n,
   output logic               lane_en,
   output logic [WIDTH-1:0]   lane_din,
   input  logic [WIDTH-1:0]   lane_next
);

   typedef enum logic [2:0] {
      S_IDLE, S_CLEAR, S_READ, S_SHIFT, S_WRITE, S_PAD, S_PADWR, S_FINISH
   } state_t;

   localparam int ONE_I      = 1;
   localparam int TWO_I      = 2;
   localparam int LAST_ROW_I = HEIGHT - 1;
   localparam logic [ROW_W:0]   RCNT_ONE  = ONE_I[ROW_W:0];
   localparam logic [ROW_W:0]   RCNT_TWO  = TWO_I[ROW_W:0];
   localparam logic [ROW_W:0]   RCNT_LAST = HEIGHT[ROW_W:0];
   localparam logic [ROW_W-1:0] ROW_TWO   = TWO_I[ROW_W-1:0];
   localparam logic [ROW_W-1:0] LAST_ROW  = LAST_ROW_I[ROW_W-1:0];

   state_t          state_r, state_s;
   logic [ROW_W:0]  rcnt_r, rcnt_s, rcnt_inc_s;
   logic            bank_r, bank_s;
   logic [15:0]     gen_cnt_r, gen_cnt_s;

   assign bank    = bank_r;
   assign gen_cnt = gen_cnt_r;

   // State, row counter, bank and generation count registers.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_r   <= S_IDLE;
         rcnt_r    <= {(ROW_W+1){1'b0}};
         bank_r    <= 1'b0;
         gen_cnt_r <= 16'd0;
      end else begin
         state_r   <= state_s;
         rcnt_r    <= rcnt_s;
         bank_r    <= bank_s;
         gen_cnt_r <= gen_cnt_s;
      end
   end

   // Next-state logic; halt overrides every transition and keeps bank/count.
   always_comb begin
      state_s    = state_r;
      rcnt_s     = rcnt_r;
      bank_s     = bank_r;
      gen_cnt_s  = gen_cnt_r;
      rcnt_inc_s = rcnt_r + RCNT_ONE;
      if (halt) begin
         state_s = S_IDLE;
      end else begin
         case (state_r)
            S_IDLE: begin
               if (start) state_s = S_CLEAR;
               else       state_s = S_IDLE;
            end
            S_CLEAR: begin
               rcnt_s  = {(ROW_W+1){1'b0}};
               state_s = S_READ;
            end
            S_READ: state_s = S_SHIFT;
            S_SHIFT: begin
               // Two rows in the lanes before the first centre row is valid.
               rcnt_s = rcnt_inc_s;
               if (rcnt_inc_s >= RCNT_TWO) state_s = S_WRITE;
               else                        state_s = S_READ;
            end
            S_WRITE: begin
               if (rcnt_r == RCNT_LAST) state_s = S_PAD;
               else                     state_s = S_READ;
            end
            S_PAD:   state_s = S_PADWR;
            S_PADWR: state_s = S_FINISH;
            S_FINISH: begin
               bank_s    = ~bank_r;
               gen_cnt_s = gen_cnt_r + 16'd1;
               state_s   = S_IDLE;
            end
            default: state_s = S_IDLE;
         endcase
      end
   end

   // Output decode from state and row counter; write data passes lane_next.
   always_comb begin
      busy        = 1'b1;
      done        = 1'b0;
      mem_rd_en   = 1'b0;
      mem_rd_addr = {(ROW_W+1){1'b0}};
      mem_wr_en   = 1'b0;
      mem_wr_addr = {(ROW_W+1){1'b0}};
      mem_wr_data = {WIDTH{1'b0}};
      lane_clr_n  = 1'b1;
      lane_en     = 1'b0;
      lane_din    = {WIDTH{1'b0}};
      case (state_r)
         S_IDLE:  busy = 1'b0;
         S_CLEAR: lane_clr_n = 1'b0;
         S_READ: begin
            mem_rd_en   = 1'b1;
            mem_rd_addr = {bank_r, rcnt_r[ROW_W-1:0]};
         end
         S_SHIFT: begin
            lane_en  = 1'b1;
            lane_din = mem_rd_data;
         end
         S_WRITE: begin
            // Centre lane stage lags the last shifted row by one.
            mem_wr_en   = 1'b1;
            mem_wr_addr = {~bank_r, rcnt_r[ROW_W-1:0] - ROW_TWO};
            mem_wr_data = lane_next;
         end
         S_PAD: lane_en = 1'b1;
         S_PADWR: begin
            mem_wr_en   = 1'b1;
            mem_wr_addr = {~bank_r, LAST_ROW};
            mem_wr_data = lane_next;
         end
         // An abort arriving in the final cycle suppresses completion.
         S_FINISH: done = ~halt;
         default:  busy = 1'b0;
      endcase
   end

endmodule

// File: doc/life_row_sequencer.md
Name: life_row_sequencer

Overview:
- Sequences one Game-of-Life generation through a row of WIDTH shredder column lanes. Each lane is a 3-deep shift cell with enable, din, neighbour sums and next_state.
- Streams rows of the current generation from a ping-pong frame memory into the lanes, one row per enable pulse. Pads the top and bottom with dead rows.
- Writes each computed next-generation row into the opposite bank, then flips banks.
- Sits between the frame memory and the lane array. Software or a top-level FSM drives start.

Parameters:
- WIDTH, 32, number of columns/lanes; bit i of every row word is column i.
- HEIGHT, 32, number of rows per frame; must be at least 2.
- ROW_W, 5, row address width; 2**ROW_W >= HEIGHT.

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- start  in  1  request one generation; sampled only in IDLE
- halt  in  1  synchronous abort; returns to IDLE from any state
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse on generation completion
- bank  out  1  bank holding the current generation
- gen_cnt  out  16  completed generations; wraps 0xFFFF->0
- mem_rd_en  out  1  row read strobe
- mem_rd_addr  out  ROW_W+1  {bank, row}
- mem_rd_data  in  WIDTH  row data, valid exactly one cycle after mem_rd_en
- mem_wr_en  out  1  row write strobe
- mem_wr_addr  out  ROW_W+1  {~bank, row}
- mem_wr_data  out  WIDTH  next-generation row
- lane_clr_n  out  1  to all lane rstn; low clears lane shift registers
- lane_en  out  1  to all lane enable
- lane_din  out  WIDTH  to lane din, bit i to lane i
- lane_next  in  WIDTH  from lane next_state, bit i from lane i

Behaviour:
- Reset (async, rstn=0):
  - state=IDLE, bank=0, gen_cnt=0, row counter rcnt=0.
  - All strobes and done = 0; lane_clr_n=1; lane_din=0.
  - Applies immediately, including mid-generation; a partial write bank is abandoned.
- Outputs are Moore-decoded from state and rcnt. Only mem_wr_data combinationally passes lane_next.
- States and transitions:
  - IDLE: start=1 -> CLEAR. start asserted while busy is ignored (not queued).
  - CLEAR: lane_clr_n=0, rcnt<=0 -> READ.
  - READ: mem_rd_en=1, mem_rd_addr={bank,rcnt} -> SHIFT.
  - SHIFT: lane_en=1, lane_din=mem_rd_data, rcnt<=rcnt+1. Next state is WRITE if the new rcnt>=2, else READ.
  - WRITE: mem_wr_en=1, mem_wr_addr={~bank,rcnt-2}, mem_wr_data=lane_next. Next state is PAD if rcnt==HEIGHT, else READ.
  - PAD: lane_en=1, lane_din=0 (bottom dead row) -> PADWR.
  - PADWR: mem_wr_en=1, mem_wr_addr={~bank,HEIGHT-1}, mem_wr_data=lane_next -> FINISH.
  - FINISH: done=1, bank<=~bank, gen_cnt<=gen_cnt+1 -> IDLE.
- Window rule: after row r+1 is shifted, the lane centre stage holds row r, so lane_next is next-gen row r. The cleared lanes supply the dead row above row 0.
- Horizontal edges: lanes 0 and WIDTH-1 see dead neighbours. This is fixed by lane wiring, not this block.
- Writes: exactly HEIGHT per generation, in row order 0..HEIGHT-1, never to bank.
- Latency: done is high in cycle 3*HEIGHT+3 after the edge that samples start (the CLEAR cycle is cycle 1). busy is high for exactly cycles 1..3*HEIGHT+3.
- halt has priority over every transition:
  - Next state is IDLE; bank and gen_cnt are unchanged; no done.
  - Strobes drop the following cycle.
  - halt and start together in IDLE: stay IDLE.
- rcnt never exceeds HEIGHT; mem_rd_addr row field is always <HEIGHT.
- Back-to-back: start held high re-launches from the IDLE cycle after FINISH; the new generation reads the new bank.

Test Plan:
- WIDTH=5, HEIGHT=5, bank0 vertical blinker (rows 1,2,3 = 5'b00100), behavioural lane model -> bank1 rows {0,0,5'b01110,0,0}. Then bank=1, gen_cnt=1, done pulse in cycle 18.
- Same frame, start held high for 2 generations -> bank0 restored to the vertical blinker, bank=0, gen_cnt=2, two done pulses 19 cycles apart.
- HEIGHT=5, block (2x2) at rows 3-4, cols 3-4 (bottom-right corner) -> unchanged in the write bank, confirming dead padding at bottom/right. Exactly 5 writes at addresses 8..12 ({1,row}).
- start pulsed during SHIFT of row 2 -> ignored: one done only, 5 writes, gen_cnt=1.
- halt asserted in the third WRITE cycle -> IDLE next cycle, busy=0, no done, bank=0, gen_cnt unchanged. A fresh start then completes normally.
- rstn dropped mid-PAD -> strobes 0 asynchronously, bank=0, gen_cnt=0. After release, a start produces a correct generation from bank 0.
